// File: rtl/ram_sync.sv
// ram_sync: synchronous single-port RAM with a REQ/ACK handshake and a
// programmable wait-state counter that models slow SRAM parts.
// Optional feature macro: RAM_SYNC_PARITY_EN (per-word even parity, PERR/PINV ports).
module ram_sync #(
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  ACK,
  output logic                  BUSY
`ifdef RAM_SYNC_PARITY_EN
  ,
  output logic                  PERR,
  input  logic                  PINV
`endif
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH = 8;
`ifdef RAM_SYNC_PARITY_EN
  localparam int unsigned WORD_WIDTH = DATA_WIDTH + 1;
`else
  localparam int unsigned WORD_WIDTH = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [ADDR_WIDTH-1:0] a_l;
  logic [DATA_WIDTH-1:0] d_l;
  logic                  we_l;
`ifdef RAM_SYNC_PARITY_EN
  logic                  pinv_l;
`endif

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic                  commit_c;
  logic                  wr_c;
  logic [WORD_WIDTH-1:0] wr_word_c;
  logic [WORD_WIDTH-1:0] rd_word_c;

  // Commit happens on the ACCESS edge where the wait counter has drained;
  // reset on that same edge suppresses the write.
  assign commit_c = (state == S_ACCESS) && (cnt == CNT_WIDTH'(0));
  assign wr_c     = commit_c && we_l && !RST;
  assign rd_word_c = mem[a_l];

`ifdef RAM_SYNC_PARITY_EN
  // Even parity over the data, optionally inverted for fault injection.
  assign wr_word_c = {(^d_l) ^ pinv_l, d_l};
`else
  assign wr_word_c = d_l;
`endif

  // Storage array: no reset, written only on a clean write commit.
  always_ff @(posedge CLK) begin
    if (wr_c) begin
      mem[a_l] <= wr_word_c;
    end
  end

  // Handshake FSM, request latches, wait counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= CNT_WIDTH'(0);
      a_l   <= ADDR_WIDTH'(0);
      d_l   <= DATA_WIDTH'(0);
      we_l  <= 1'b0;
      Q     <= DATA_WIDTH'(0);
      ACK   <= 1'b0;
      BUSY  <= 1'b0;
`ifdef RAM_SYNC_PARITY_EN
      pinv_l <= 1'b0;
      PERR   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          ACK <= 1'b0;
          if (REQ) begin
            a_l   <= A;
            d_l   <= D;
            we_l  <= WE;
`ifdef RAM_SYNC_PARITY_EN
            pinv_l <= PINV;
`endif
            cnt   <= CNT_WIDTH'(WAIT_STATES);
            BUSY  <= 1'b1;
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt != CNT_WIDTH'(0)) begin
            cnt <= cnt - CNT_WIDTH'(1);
          end else begin
            if (!we_l) begin
              Q <= rd_word_c[DATA_WIDTH-1:0];
`ifdef RAM_SYNC_PARITY_EN
              PERR <= rd_word_c[DATA_WIDTH] ^ (^rd_word_c[DATA_WIDTH-1:0]);
`endif
            end
            ACK   <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          ACK   <= 1'b0;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          ACK   <= 1'b0;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sync.sv
// Scoreboard bench for ram_sync: three instances with WAIT_STATES 0, 3 and 2.
// Build with RAM_SYNC_PARITY_EN defined to also exercise the parity path.
module tb_ram_sync;

  typedef struct packed {
    logic [7:0] q;
    logic       chk_perr;
    logic       perr;
  } exp_t;

  logic        clk;
  logic        rst  [3];
  logic        req  [3];
  logic        we   [3];
  logic [14:0] a    [3];
  logic [7:0]  d    [3];
  logic [7:0]  q    [3];
  logic        ack  [3];
  logic        busy [3];
  logic        perr [3];
  logic        pinv [3];

  int ws_of [3] = '{0, 3, 2};
  int checks = 0;
  int errors = 0;

  exp_t sbq0 [$];
  exp_t sbq1 [$];
  exp_t sbq2 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_sync #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .WAIT_STATES(0)) u0 (
    .CLK(clk), .RST(rst[0]), .REQ(req[0]), .WE(we[0]), .A(a[0]), .D(d[0]),
    .Q(q[0]), .ACK(ack[0]), .BUSY(busy[0])
`ifdef RAM_SYNC_PARITY_EN
    , .PERR(perr[0]), .PINV(pinv[0])
`endif
  );

  ram_sync #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .WAIT_STATES(3)) u1 (
    .CLK(clk), .RST(rst[1]), .REQ(req[1]), .WE(we[1]), .A(a[1]), .D(d[1]),
    .Q(q[1]), .ACK(ack[1]), .BUSY(busy[1])
`ifdef RAM_SYNC_PARITY_EN
    , .PERR(perr[1]), .PINV(pinv[1])
`endif
  );

  ram_sync #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .WAIT_STATES(2)) u2 (
    .CLK(clk), .RST(rst[2]), .REQ(req[2]), .WE(we[2]), .A(a[2]), .D(d[2]),
    .Q(q[2]), .ACK(ack[2]), .BUSY(busy[2])
`ifdef RAM_SYNC_PARITY_EN
    , .PERR(perr[2]), .PINV(pinv[2])
`endif
  );

`ifndef RAM_SYNC_PARITY_EN
  assign perr[0] = 1'b0;
  assign perr[1] = 1'b0;
  assign perr[2] = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input exp_t e);
    case (idx)
      0: sbq0.push_back(e);
      1: sbq1.push_back(e);
      default: sbq2.push_back(e);
    endcase
  endtask

  // Monitor side of the scoreboard: every ACK pops one expectation.
  task automatic mon_check(input int idx, input logic [7:0] qv, input logic pv);
    exp_t e;
    bit   have;
    have = 1'b0;
    e = '0;
    case (idx)
      0: if (sbq0.size() != 0) begin e = sbq0.pop_front(); have = 1'b1; end
      1: if (sbq1.size() != 0) begin e = sbq1.pop_front(); have = 1'b1; end
      default: if (sbq2.size() != 0) begin e = sbq2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack dut%0d: got ACK, expected no ACK", idx);
    end else begin
      chk($sformatf("q_on_ack_dut%0d", idx), 32'(qv), 32'(e.q));
      if (e.chk_perr) chk($sformatf("perr_on_ack_dut%0d", idx), 32'(pv), 32'(e.perr));
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack[i] === 1'b1) mon_check(i, q[i], perr[i]);
    end
  end

  // One complete access with handshake timing checks; data is checked by the monitor.
  task automatic access(input int idx, input logic wr, input logic [14:0] addr,
                        input logic [7:0] data, input logic p, input bit hold,
                        input bit chg, input logic [7:0] exp_q,
                        input logic chk_p, input logic exp_p);
    int lat;
    bit got;
    exp_t e;
    @(negedge clk);
    req[idx] = 1'b1;
    we[idx]  = wr;
    a[idx]   = addr;
    d[idx]   = data;
    pinv[idx] = p;
    e.q = exp_q;
    e.chk_perr = chk_p;
    e.perr = exp_p;
    push_exp(idx, e);
    @(posedge clk);
    #1;
    chk("busy_on_accept", 32'(busy[idx]), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 300) begin
      @(negedge clk);
      if (lat == 0) begin
        if (!hold) req[idx] = 1'b0;
        pinv[idx] = 1'b0;
        if (chg) begin
          a[idx] = addr ^ 15'h0001;
          d[idx] = ~data;
        end
      end
      @(posedge clk);
      #1;
      lat++;
      if (ack[idx] === 1'b1) got = 1'b1;
    end
    chk("ack_latency", 32'(lat), 32'(ws_of[idx] + 1));
    chk("busy_during_ack", 32'(busy[idx]), 32'd1);
    @(posedge clk);
    #1;
    chk("ack_one_cycle", 32'(ack[idx]), 32'd0);
    chk("busy_after_ack", 32'(busy[idx]), 32'd0);
    @(negedge clk);
    req[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0;
      a[i] = '0; d[i] = '0; pinv[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_q_dut%0d", i), 32'(q[i]), 32'd0);
      chk($sformatf("reset_ack_dut%0d", i), 32'(ack[i]), 32'd0);
      chk($sformatf("reset_busy_dut%0d", i), 32'(busy[i]), 32'd0);
`ifdef RAM_SYNC_PARITY_EN
      chk($sformatf("reset_perr_dut%0d", i), 32'(perr[i]), 32'd0);
`endif
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // WAIT_STATES=0: basic write/read, address extremes, hold of Q, late A/D changes
    access(0, 1'b1, 15'h0010, 8'h5A, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
    access(0, 1'b0, 15'h0010, 8'h00, 1'b0, 0, 0, 8'h5A, 1'b1, 1'b0);
    access(0, 1'b1, 15'h7FFF, 8'hA5, 1'b0, 0, 0, 8'h5A, 1'b0, 1'b0);
    access(0, 1'b1, 15'h0000, 8'h3C, 1'b0, 0, 0, 8'h5A, 1'b0, 1'b0);
    access(0, 1'b0, 15'h7FFF, 8'h00, 1'b0, 0, 0, 8'hA5, 1'b1, 1'b0);
    access(0, 1'b0, 15'h0000, 8'h00, 1'b0, 0, 0, 8'h3C, 1'b1, 1'b0);
    access(0, 1'b1, 15'h0000, 8'h99, 1'b0, 0, 0, 8'h3C, 1'b0, 1'b0);
    access(0, 1'b1, 15'h0020, 8'h42, 1'b0, 0, 0, 8'h3C, 1'b0, 1'b0);
    access(0, 1'b1, 15'h0021, 8'h43, 1'b0, 0, 0, 8'h3C, 1'b0, 1'b0);
    access(0, 1'b0, 15'h0020, 8'h00, 1'b0, 0, 1, 8'h42, 1'b1, 1'b0);
    access(0, 1'b1, 15'h0022, 8'h55, 1'b0, 0, 1, 8'h42, 1'b0, 1'b0);
    access(0, 1'b0, 15'h0022, 8'h00, 1'b0, 0, 0, 8'h55, 1'b1, 1'b0);
    access(0, 1'b0, 15'h0000, 8'h00, 1'b0, 0, 0, 8'h99, 1'b1, 1'b0);
`ifdef RAM_SYNC_PARITY_EN
    access(0, 1'b1, 15'h0030, 8'h01, 1'b1, 0, 0, 8'h99, 1'b0, 1'b0);
    access(0, 1'b0, 15'h0030, 8'h00, 1'b0, 0, 0, 8'h01, 1'b1, 1'b1);
    access(0, 1'b1, 15'h0030, 8'h01, 1'b0, 0, 0, 8'h01, 1'b0, 1'b0);
    access(0, 1'b0, 15'h0030, 8'h00, 1'b0, 0, 0, 8'h01, 1'b1, 1'b0);
`endif

    // WAIT_STATES=3: REQ held high through the whole access must not retrigger
    access(1, 1'b1, 15'h0005, 8'hC3, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
    access(1, 1'b0, 15'h0005, 8'h00, 1'b0, 1, 0, 8'hC3, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("no_second_access_busy", 32'(busy[1]), 32'd0);

    // WAIT_STATES=2: reset on the write commit edge aborts the write
    access(2, 1'b1, 15'h0100, 8'h11, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
    access(2, 1'b0, 15'h0100, 8'h00, 1'b0, 0, 0, 8'h11, 1'b1, 1'b0);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; a[2] = 15'h0100; d[2] = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ack", 32'(ack[2]), 32'd0);
    chk("abort_busy", 32'(busy[2]), 32'd0);
    chk("abort_q", 32'(q[2]), 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    access(2, 1'b0, 15'h0100, 8'h00, 1'b0, 0, 0, 8'h11, 1'b1, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq0.size() + sbq1.size() + sbq2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
